lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Parametrised, multi-cycle load/store controller between the MEM stage and a request/grant/response data bus. Replaces the single-cycle negedge DPI access with a registered FSM.
- Handles XLEN 32 or 64, byte-lane masking, and sign/zero extension.
- Adds bus wait states, an error path and a response timeout.

Parameters:
XLEN, 32, data width (32 or 64); lane count NB = XLEN/8
ADDR_W, 32, address width
TIMEOUT_CYC, 255, max cycles in WAIT before forced error (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  MEM-stage access request
req_ready  out  1  controller can accept a request
req_wen  in  1  1 = store, 0 = load
req_op  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, LSB-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load result (0 for stores/errors)
resp_err  out  1  qualifies resp_valid: access failed
bus_req  out  1  bus request, held until grant
bus_we  out  1  write enable
bus_addr  out  ADDR_W  address aligned down to NB bytes
bus_wdata  out  XLEN  store data shifted into lanes
bus_wmask  out  NB  byte-lane write strobes (0 on reads)
bus_gnt  in  1  request accepted
bus_rvalid  in  1  response (read data or write ack)
bus_rdata  in  XLEN  read data, full bus word
bus_err  in  1  qualifies bus_rvalid

Behaviour:
- Reset (rst=0, async): state IDLE, timeout counter 0. All outputs 0 except req_ready=1.
- States:
  - IDLE: req_ready=1. On req_valid, latch wen/op/addr/wdata, compute off = addr mod NB.
    - Illegal op goes to RESP with err=1 and no bus access. Illegal ops: 111; 011/110 when XLEN=32; any op with bit2 set on a store.
    - Otherwise go to REQ.
  - REQ: bus_req=1, bus outputs stable. Stay until bus_gnt, then go to WAIT and clear the counter.
  - WAIT: bus_req=0. Sample bus_rvalid, then go to RESP.
    - err = bus_err.
    - For loads, latch the extracted data.
    - The counter increments each WAIT cycle. When it reaches TIMEOUT_CYC without rvalid, go to RESP with err=1 and discard any later rvalid.
  - RESP: resp_valid=1, resp_rdata and resp_err registered. Next state IDLE.
- req_ready=0 in REQ/WAIT/RESP. A new request is accepted at the earliest in the cycle after RESP.
- Minimum latency: accept at cycle N, resp_valid at N+3 (gnt at N+1, rvalid at N+2).
- bus_rvalid is ignored outside WAIT.
- Store lanes:
  - bus_wdata = req_wdata shifted left by 8*off.
  - bus_wmask = size mask shifted left by off, where size mask is B=1, H=3, W=0xF, D=0xFF.
  - Bits shifted beyond NB are dropped.
- Load extract: field = bus_rdata >> 8*off, truncated to size. Sign-extend for B/H/W; zero-extend for BU/HU/WU and for D.
- Misalignment handling with the macro undefined: access proceeds unchecked; lanes crossing the word boundary are dropped or read as 0.
- resp_rdata = 0 whenever resp_err=1 or wen=1.

Optional Feature:
MISALIGN_CHECK_EN
- Defined: in IDLE, an access with off not a multiple of its size goes straight to RESP with resp_err=1. No bus_req is issued.
- Undefined: no check; behaviour as in the misalignment bullet above.

Test Plan:
- XLEN=32: load W at 0x100; gnt at +1, rvalid at +2 with rdata 0xDEADBEEF -> resp_valid at +3, rdata 0xDEADBEEF, err 0.
- Load B at 0x103, rdata 0x80112233 -> rdata 0xFFFFFF80. Same access as BU -> 0x00000080.
- Store H at 0x102, wdata 0x0000ABCD, gnt delayed 4 cycles -> bus_req held 4 cycles, bus_addr 0x100, wmask 0b1100, wdata 0xABCD0000. Write ack gives resp_valid, rdata 0.
- No rvalid after grant, TIMEOUT_CYC=8 -> resp_valid with err=1 exactly 8 cycles after entering WAIT. A late rvalid is ignored and req_ready=1 again.
- Reset asserted in WAIT -> outputs clear immediately, req_ready=1. After release, a new load completes normally.
- MISALIGN_CHECK_EN defined, load W at 0x102 -> resp_err=1 at +1, bus_req never asserted. Same test with the macro undefined -> bus access at 0x100.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Signal bundle between the MEM stage, the LSU memory controller and the data bus.
// master = controller view; slave = MEM-stage / bus view.
interface lsu_mem_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [NB-1:0]     bus_wmask;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_err;

  modport master (
    input  req_valid, req_wen, req_op, req_addr, req_wdata,
           bus_gnt, bus_rvalid, bus_rdata, bus_err,
    output req_ready, resp_valid, resp_rdata, resp_err,
           bus_req, bus_we, bus_addr, bus_wdata, bus_wmask
  );

  modport slave (
    output req_valid, req_wen, req_op, req_addr, req_wdata,
           bus_gnt, bus_rvalid, bus_rdata, bus_err,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           bus_req, bus_we, bus_addr, bus_wdata, bus_wmask
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store controller: MEM-stage request -> req/gnt/rvalid bus -> response pulse.
// Optional MISALIGN_CHECK_EN rejects accesses whose offset is not a multiple of the access size.
module lsu_mem_ctrl #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_ctrl_if.master    io
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             wen_p0;
  logic [2:0]       op_p0;
  logic [OFF_W-1:0] off_p0;
  logic [OFF_W-1:0] off_in;
  logic             illegal;
  logic             misalign;

  function automatic logic [NB-1:0] size_mask(input logic [2:0] op);
    logic [7:0] m;
    case (op[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return NB'(m);
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                              input logic [2:0]      op,
                                              input logic [OFF_W-1:0] off);
    logic [XLEN-1:0] f;
    f = word >> {off, 3'b000};
    case (op)
      3'b000:  return XLEN'($signed(f[7:0]));
      3'b001:  return XLEN'($signed(f[15:0]));
      3'b010:  return XLEN'($signed(f[31:0]));
      3'b100:  return XLEN'(f[7:0]);
      3'b101:  return XLEN'(f[15:0]);
      3'b110:  return XLEN'(f[31:0]);
      default: return f;
    endcase
  endfunction

  assign off_in  = io.req_addr[OFF_W-1:0];
  assign illegal = (io.req_op == 3'b111)
                || ((XLEN == 32) && ((io.req_op == 3'b011) || (io.req_op == 3'b110)))
                || (io.req_wen && io.req_op[2]);

`ifdef MISALIGN_CHECK_EN
  logic [7:0] align_m;
  assign align_m  = (8'd1 << io.req_op[1:0]) - 8'd1;
  assign misalign = (off_in & OFF_W'(align_m)) != '0;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    io.req_ready  = 1'b0;
    io.bus_req    = 1'b0;
    io.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        io.req_ready = 1'b1;
        if (io.req_valid) state_nxt = (illegal || misalign) ? RESP : REQ;
      end
      REQ: begin
        io.bus_req = 1'b1;
        if (io.bus_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (io.bus_rvalid || (cnt == CNT_W'(TIMEOUT_CYC - 1))) state_nxt = RESP;
      end
      default: begin
        io.resp_valid = 1'b1;
        state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      wen_p0        <= 1'b0;
      op_p0         <= '0;
      off_p0        <= '0;
      io.bus_we     <= 1'b0;
      io.bus_addr   <= '0;
      io.bus_wdata  <= '0;
      io.bus_wmask  <= '0;
      io.resp_rdata <= '0;
      io.resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // accept: latch the request and pre-compute the bus lanes
        IDLE: if (io.req_valid) begin
          wen_p0        <= io.req_wen;
          op_p0         <= io.req_op;
          off_p0        <= off_in;
          cnt           <= '0;
          io.bus_we     <= io.req_wen;
          io.bus_addr   <= {io.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          io.bus_wdata  <= io.req_wen ? (io.req_wdata << {off_in, 3'b000}) : '0;
          io.bus_wmask  <= io.req_wen ? (size_mask(io.req_op) << off_in) : '0;
          io.resp_err   <= illegal || misalign;
          io.resp_rdata <= '0;
        end
        REQ: cnt <= '0;
        // response or timeout; a late rvalid after this point is never sampled
        WAIT: begin
          if (io.bus_rvalid) begin
            io.resp_err   <= io.bus_err;
            io.resp_rdata <= (wen_p0 || io.bus_err) ? '0 : extract(io.bus_rdata, op_p0, off_p0);
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            io.resp_err   <= 1'b1;
            io.resp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl (XLEN=32, TIMEOUT_CYC=8) with a cycle-window reference model.
module tb_lsu_mem_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  lsu_mem_ctrl_if #(.XLEN(32), .ADDR_W(32)) io();

  lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .io(io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // expected transaction timeline, in cycle numbers
  int          t_acc = -10, t_gnt = -10, t_resp = -10;
  logic        txn_ok, exp_we, exp_err, chk_en = 1'b0;
  logic [31:0] exp_rdata, exp_baddr, exp_bwdata;
  logic [3:0]  exp_wmask;
  int          breq_cnt, resp_cnt, last_resp_cyc;
  logic        last_err;
  logic [31:0] last_rdata, last_baddr, last_bwdata;
  logic [3:0]  last_wmask;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void model(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rd, input logic berr,
                                input logic no_rv, output logic ok, output logic err,
                                output logic [31:0] rdata, output logic [31:0] baddr,
                                output logic [3:0] wmask, output logic [31:0] bwdata);
    int size, off;
    logic [63:0] field, m;
    size = 1 << op[1:0];
    off  = int'(addr % 4);
    ok   = !(op == 3'd7 || op == 3'd3 || op == 3'd6 || (wen && op[2]));
`ifdef MISALIGN_CHECK_EN
    if (off % size != 0) ok = 1'b0;
`endif
    baddr  = addr - 32'(off);
    wmask  = wen ? 4'((32'd1 << size) - 32'd1 << off) : 4'd0;
    bwdata = 32'({32'd0, wdata} << (8 * off));
    m      = (64'd1 << (8 * size)) - 64'd1;
    field  = ({32'd0, rd} >> (8 * off)) & m;
    if (op <= 3'd2 && field[8 * size - 1]) field = field | ~m;
    err   = !ok || no_rv || berr;
    rdata = (err || wen) ? 32'd0 : field[31:0];
  endfunction

  // per-cycle compare against the expected timeline
  always @(posedge clk) begin
    #1;
    if (rst && chk_en) begin
      chk("req_ready", 64'(io.req_ready), 64'(!(cyc > t_acc && cyc <= t_resp)));
      chk("bus_req", 64'(io.bus_req), 64'(cyc > t_acc && cyc <= t_gnt));
      chk("resp_valid", 64'(io.resp_valid), 64'(cyc == t_resp));
      if (io.bus_req) begin
        breq_cnt++;
        last_baddr = io.bus_addr; last_wmask = io.bus_wmask; last_bwdata = io.bus_wdata;
        chk("bus_addr", 64'(io.bus_addr), 64'(exp_baddr));
        chk("bus_we", 64'(io.bus_we), 64'(exp_we));
        chk("bus_wmask", 64'(io.bus_wmask), 64'(exp_wmask));
        if (exp_we) chk("bus_wdata", 64'(io.bus_wdata), 64'(exp_bwdata));
      end
      if (io.resp_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc; last_err = io.resp_err; last_rdata = io.resp_rdata;
        chk("resp_err", 64'(io.resp_err), 64'(exp_err));
        chk("resp_rdata", 64'(io.resp_rdata), 64'(exp_rdata));
      end
    end
  end

  task automatic issue(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd, input logic berr,
                       input int g, input int r, input logic no_rv);
    logic ok;
    @(negedge clk);
    model(wen, op, addr, wdata, rd, berr, no_rv, ok, exp_err, exp_rdata, exp_baddr, exp_wmask, exp_bwdata);
    exp_we   = wen;
    txn_ok   = ok;
    breq_cnt = 0;
    resp_cnt = 0;
    t_acc    = cyc;
    t_gnt    = ok ? cyc + 1 + g : -10;
    t_resp   = !ok ? cyc + 1 : (no_rv ? cyc + 2 + g + TO : cyc + 3 + g + r);
    io.req_valid = 1'b1; io.req_wen = wen; io.req_op = op; io.req_addr = addr; io.req_wdata = wdata;
    @(negedge clk);
    io.req_valid = 1'b0; io.req_wen = 1'b0; io.req_op = 3'd0; io.req_addr = '0; io.req_wdata = '0;
  endtask

  task automatic bus_play(input int g, input int r, input logic no_rv, input logic [31:0] rd,
                          input logic berr);
    if (txn_ok) begin
      repeat (g) @(negedge clk);
      io.bus_gnt = 1'b1;
      @(negedge clk);
      io.bus_gnt = 1'b0;
      if (!no_rv) begin
        repeat (r) @(negedge clk);
        io.bus_rvalid = 1'b1; io.bus_rdata = rd; io.bus_err = berr;
        @(negedge clk);
      end else begin
        while (cyc < t_resp) @(negedge clk);
        io.bus_rvalid = 1'b1; io.bus_rdata = rd; io.bus_err = berr;
        repeat (2) @(negedge clk);
      end
      io.bus_rvalid = 1'b0; io.bus_rdata = '0; io.bus_err = 1'b0;
    end
    while (cyc <= t_resp + 1) @(negedge clk);
  endtask

  task automatic run(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rd, input logic berr,
                     input int g, input int r, input logic no_rv);
    issue(wen, op, addr, wdata, rd, berr, g, r, no_rv);
    bus_play(g, r, no_rv, rd, berr);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(io.req_ready), 64'd1);
    chk({tag, "_bus_req"}, 64'(io.bus_req), 64'd0);
    chk({tag, "_resp_valid"}, 64'(io.resp_valid), 64'd0);
    chk({tag, "_resp_rdata"}, 64'(io.resp_rdata), 64'd0);
    chk({tag, "_resp_err"}, 64'(io.resp_err), 64'd0);
    chk({tag, "_bus_we"}, 64'(io.bus_we), 64'd0);
    chk({tag, "_bus_addr"}, 64'(io.bus_addr), 64'd0);
    chk({tag, "_bus_wmask"}, 64'(io.bus_wmask), 64'd0);
    chk({tag, "_bus_wdata"}, 64'(io.bus_wdata), 64'd0);
  endtask

  initial begin
    io.req_valid = 1'b0; io.req_wen = 1'b0; io.req_op = 3'd0; io.req_addr = '0; io.req_wdata = '0;
    io.bus_gnt = 1'b0; io.bus_rvalid = 1'b0; io.bus_rdata = '0; io.bus_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b1;
    chk_en = 1'b1;

    run(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0);
    chk("ldw_rdata", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("ldw_err", 64'(last_err), 64'd0);
    chk("ldw_latency", 64'(last_resp_cyc - t_acc), 64'd3);

    run(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1'b0, 1, 2, 1'b0);
    chk("lb_rdata", 64'(last_rdata), 64'h0000_0000_FFFF_FF80);
    run(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1'b0, 0, 0, 1'b0);
    chk("lbu_rdata", 64'(last_rdata), 64'h80);

    run(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'hFFFFFFFF, 1'b0, 3, 0, 1'b0);
    chk("sh_req_cycles", 64'(breq_cnt), 64'd4);
    chk("sh_addr", 64'(last_baddr), 64'h100);
    chk("sh_wmask", 64'(last_wmask), 64'hC);
    chk("sh_wdata", 64'(last_bwdata), 64'h0000_0000_ABCD_0000);
    chk("sh_rdata", 64'(last_rdata), 64'd0);
    chk("sh_err", 64'(last_err), 64'd0);

    run(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1'b0, 0, 1, 1'b0);
    chk("lh_rdata", 64'(last_rdata), 64'h0000_0000_FFFF_8001);
    run(1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 1'b0, 2, 0, 1'b0);
    chk("lhu_rdata", 64'(last_rdata), 64'h8001);

    run(1'b1, 3'b000, 32'h101, 32'h0000005A, 32'h0, 1'b0, 0, 0, 1'b0);
    chk("sb_wmask", 64'(last_wmask), 64'h2);
    chk("sb_wdata", 64'(last_bwdata), 64'h5A00);

    run(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 1'b1, 0, 0, 1'b0);
    chk("buserr_err", 64'(last_err), 64'd1);
    chk("buserr_rdata", 64'(last_rdata), 64'd0);

    run(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 1'b0, 1, 0, 1'b1);
    chk("timeout_err", 64'(last_err), 64'd1);
    chk("timeout_wait_cycles", 64'(last_resp_cyc - (t_acc + 3)), 64'd8);
    chk("timeout_resp_count", 64'(resp_cnt), 64'd1);

    run(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0);
    chk("op111_err", 64'(last_err), 64'd1);
    chk("op111_no_bus", 64'(breq_cnt), 64'd0);
    chk("op111_latency", 64'(last_resp_cyc - t_acc), 64'd1);
    run(1'b1, 3'b101, 32'h100, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0);
    chk("sthu_err", 64'(last_err), 64'd1);
    run(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0);
    chk("ld_d32_err", 64'(last_err), 64'd1);

    run(1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFEBABE, 1'b0, 0, 0, 1'b0);
`ifdef MISALIGN_CHECK_EN
    chk("mis_err", 64'(last_err), 64'd1);
    chk("mis_no_bus", 64'(breq_cnt), 64'd0);
    chk("mis_latency", 64'(last_resp_cyc - t_acc), 64'd1);
`else
    chk("mis_addr", 64'(last_baddr), 64'h100);
    chk("mis_rdata", 64'(last_rdata), 64'h0000CAFE);
    chk("mis_err", 64'(last_err), 64'd0);
`endif

    issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 1'b0, 0, 0, 1'b0);
    io.bus_gnt = 1'b1;
    @(negedge clk);
    io.bus_gnt = 1'b0;
    rst = 1'b0;
    t_acc = -10; t_gnt = -10; t_resp = -10;
    #1;
    chk_idle_outputs("rst_in_wait");
    @(negedge clk);
    rst = 1'b1;
    run(1'b0, 3'b010, 32'h204, 32'h0, 32'h0BADF00D, 1'b0, 1, 1, 1'b0);
    chk("post_rst_rdata", 64'(last_rdata), 64'h0BAD_F00D);
    chk("post_rst_err", 64'(last_err), 64'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
